sw_debounce: RTL
================

// Module: sw_debounce
// PURPOSE
//  Input conditioning stage directly upstream of the SoC top's sw_i bus.
//  Synchronises the raw asynchronous board switches into the clk domain and debounces them.
//  Outputs the clean switch vector plus one-cycle rise/fall/change strobes.
//  Clean vector drives CLK_DIV speed select, register-read select and display select.
// PARAMETERS
//  WIDTH         16      number of switch inputs
//  SYNC_STAGES   2       synchroniser flops per bit (>=2)
//  TICK_DIV      100000  clk cycles per sample tick (1 ms @ 100 MHz); >=1, 1 = tick every cycle
//  STABLE_TICKS  5       consecutive differing samples required to accept a new level (>=1)
// PORTS
//  clk        in   1      system clock (board clk, not Clk_CPU)
//  rst        in   1      asynchronous, active-high reset
//  sw_raw     in   WIDTH  raw switch pins, asynchronous to clk
//  sw_o       out  WIDTH  debounced switch levels (feeds sw_i)
//  rise_o     out  WIDTH  1-cycle pulse per bit on accepted 0->1
//  fall_o     out  WIDTH  1-cycle pulse per bit on accepted 1->0
//  changed_o  out  1      1-cycle pulse: OR of all rise_o|fall_o bits in that cycle
// BEHAVIOUR
//  Reset (async assert, released on clk edge):
//   - sync chain, tick counter, per-bit counters = 0.
//   - sw_o, rise_o, fall_o, changed_o = 0.
//  Synchroniser:
//   - sync[i] = sw_raw[i] delayed SYNC_STAGES clk edges.
//   - No logic on sw_raw before the first flop.
//  Tick generator:
//   - tcnt counts 0..TICK_DIV-1 and wraps to 0.
//   - tick = 1 for exactly one cycle when tcnt == TICK_DIV-1.
//   - TICK_DIV=1: tick is constantly 1.
//  Per-bit filter (all bits independent, same tick), on a tick cycle only:
//   - sync[i] == sw_o[i]: cnt[i] <= 0 (glitch cancels progress).
//   - sync[i] != sw_o[i] and cnt[i] == STABLE_TICKS-1: sw_o[i] <= sync[i], cnt[i] <= 0.
//   - otherwise: cnt[i] <= cnt[i]+1.
//   - Non-tick cycles: cnt and sw_o hold.
//  Widths: cnt[i] is $clog2(STABLE_TICKS+1) bits; tcnt is $clog2(TICK_DIV+1) bits. Neither saturates nor overflows.
//  Strobes:
//   - rise_o/fall_o/changed_o are registered and assert in the same cycle sw_o takes its new value.
//   - Strobes deassert on the next cycle (no tick can produce two back-to-back accepts).
//   - Multiple bits accepted on the same tick assert together; changed_o is a single pulse.
//  Latency: raw edge to sw_o change is SYNC_STAGES cycles + (STABLE_TICKS-1)*TICK_DIV + 1..TICK_DIV cycles.
//  Bounce: any return to the old level on a tick before acceptance restarts the count.
//   - Pulses shorter than STABLE_TICKS ticks never reach sw_o.
//  Reset mid-count: progress is discarded and sw_o returns to 0.
//   - A switch held high re-qualifies from scratch after release and produces a rise_o pulse.
//  Power-up: switches high at reset release produce rise_o after the normal latency.
// TESTING  (bench params: WIDTH=16, SYNC_STAGES=2, TICK_DIV=4, STABLE_TICKS=3)
//  1. Reset, then sw_raw=16'h0001 held
//     -> sw_o=16'h0001 within 2+8+1..4 cycles; rise_o=16'h0001 for exactly 1 cycle; changed_o=1 same cycle.
//  2. Bit3 toggled every 5 cycles for 60 cycles, then held 0
//     -> sw_o[3] stays 0; no rise/fall/changed pulses.
//  3. sw_raw 16'h0000->16'h8001 in one cycle
//     -> sw_o=16'h8001 and rise_o=16'h8001 in the same cycle; single changed_o pulse.
//  4. From sw_o=16'h8001, sw_raw=16'h0001
//     -> fall_o=16'h8000 one cycle; sw_o=16'h0001; rise_o=0.
//  5. rst pulsed (mid-cycle, async) while cnt[0]=2, sw_raw=16'h0001
//     -> outputs 0 immediately; rise_o[0] pulses again after full latency.
//  6. Rerun scenario 1 with TICK_DIV=1
//     -> sw_o[0] rises exactly 2+3 cycles after the sw_raw edge.

Source files
------------

// File: rtl/sw_debounce.sv
// Switch input conditioning: per-bit synchroniser, shared sample tick and
// consecutive-sample debounce filter with registered rise/fall/change strobes.
module sw_debounce #(
  parameter int WIDTH        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             changed_o
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [TW-1:0]    tcnt_q;
  logic             tick;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] sw_d;
  logic [WIDTH-1:0] accept;

  // sw_raw goes straight into the first flop; nothing combinational in front of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= sw_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // With TICK_DIV = 1 the counter sits at 0 and tick is permanently high.
  assign tick = (tcnt_q == TCNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tcnt_q <= '0;
    else if (tick) tcnt_q <= '0;
    else           tcnt_q <= tcnt_q + TW'(1);
  end

  always_comb begin
    cnt_d  = cnt_q;
    sw_d   = sw_o;
    accept = '0;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == sw_o[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          accept[i] = 1'b1;
          sw_d[i]   = sync[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Strobes are registered alongside sw_o so they line up with the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      sw_o      <= '0;
      rise_o    <= '0;
      fall_o    <= '0;
      changed_o <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sw_o      <= sw_d;
      rise_o    <= accept & sync;
      fall_o    <= accept & ~sync;
      changed_o <= |accept;
    end
  end

endmodule
